// File: rtl/usb_tx_bridge.sv
// usb_tx_bridge: CPU-to-USB-serial transmit bridge.
// A small byte FIFO written by the CPU drains into a registered valid/ready
// output stage that feeds the USB serial core's host-bound byte stream.
// cpu_status gives the CPU its flow-control and sticky-overflow view.
// Optional feature macro: USB_TX_CRLF_EN (expands LF into CR LF on output).
module usb_tx_bridge #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_ovf_clr,
  output logic [15:0] cpu_status,
  output logic [7:0]  uart_in_data,
  output logic        uart_in_valid,
  input  logic        uart_in_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef USB_TX_CRLF_EN
  localparam logic [1:0] ST_CR    = 2'd2;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] level_s;
  logic          full_s;
  logic          empty_s;
  logic [7:0]    head_s;
  logic          pop_s;
  logic          push_s;
  logic [7:0]    load_data_s;
  logic [1:0]    load_state_s;

  assign level_s = wptr_q - rptr_q;
  assign full_s  = (level_s == PW'(DEPTH));
  assign empty_s = (level_s == {PW{1'b0}});
  assign head_s  = mem_q[rptr_q[AW-1:0]];

`ifdef USB_TX_CRLF_EN
  logic lf_pend_q, lf_pend_d;
  logic load_cr_s;

  // An LF leaving the FIFO is first presented as CR; the LF follows from the flag.
  always_comb begin
    load_cr_s    = (head_s == 8'h0A);
    load_data_s  = load_cr_s ? 8'h0D : head_s;
    load_state_s = load_cr_s ? ST_CR : ST_FULL;
  end
`else
  // Without CR insertion the head byte is loaded unmodified.
  always_comb begin
    load_data_s  = head_s;
    load_state_s = ST_FULL;
  end
`endif

  // Output stage: load from the FIFO when empty or when the held byte transfers.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          data_d  = load_data_s;
          state_d = load_state_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (uart_in_ready) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            data_d  = load_data_s;
            state_d = load_state_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
`ifdef USB_TX_CRLF_EN
      ST_CR: begin
        // CR accepted: present the pending LF without touching the FIFO.
        if (uart_in_ready && lf_pend_q) begin
          data_d  = 8'h0A;
          state_d = ST_FULL;
        end else begin
          state_d = ST_CR;
        end
      end
`endif
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

`ifdef USB_TX_CRLF_EN
  // Pending-LF flag: set when a CR is substituted, cleared when it transfers.
  always_comb begin
    lf_pend_d = lf_pend_q;
    if (pop_s && load_cr_s) begin
      lf_pend_d = 1'b1;
    end else if ((state_q == ST_CR) && uart_in_ready) begin
      lf_pend_d = 1'b0;
    end else begin
      lf_pend_d = lf_pend_q;
    end
  end

  // Pending-LF register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_pend_q <= 1'b0;
    end else begin
      lf_pend_q <= lf_pend_d;
    end
  end
`endif

  // Push admission (a same-cycle pop frees a slot) and sticky overflow, set beating clear.
  always_comb begin
    push_s = cpu_we && (!full_s || pop_s);
    wptr_d = push_s ? (wptr_q + {{AW{1'b0}}, 1'b1}) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + {{AW{1'b0}}, 1'b1}) : rptr_q;
    if (cpu_we && !push_s) begin
      ovf_d = 1'b1;
    end else if (cpu_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= cpu_wdata;
    end
  end

  // Pointer, output stage and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      state_q <= ST_EMPTY;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_in_valid = (state_q != ST_EMPTY);
  assign uart_in_data  = data_q;
  assign cpu_status    = {8'(level_s), 4'b0000, uart_in_valid, ovf_q,
                          (empty_s && (state_q == ST_EMPTY)), !full_s};

endmodule

// File: tb/tb_usb_tx_bridge.sv
// Scoreboard bench for usb_tx_bridge: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every transfer.
module tb_usb_tx_bridge;

  localparam int DEPTH = 16;
`ifdef USB_TX_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_ovf_clr = 1'b0;
  logic        uart_in_ready = 1'b0;
  logic [15:0] cpu_status;
  logic [7:0]  uart_in_data;
  logic        uart_in_valid;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mfifo[$];
  bit         mvalid = 1'b0;
  bit         mcr = 1'b0;
  bit         movf = 1'b0;
  bit         stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  usb_tx_bridge #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_ovf_clr   (cpu_ovf_clr),
    .cpu_status    (cpu_status),
    .uart_in_data  (uart_in_data),
    .uart_in_valid (uart_in_valid),
    .uart_in_ready (uart_in_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_status();
    int lvl;
    lvl = mfifo.size();
    return {8'(lvl), 4'b0000, mvalid, movf, (lvl == 0) && !mvalid, lvl < DEPTH};
  endfunction

  // Monitor: checks hold-while-stalled and pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        chk("hold_valid", 32'(uart_in_valid), 32'd1);
        chk("hold_data", 32'(uart_in_data), 32'(stall_data));
      end
      if (uart_in_valid && uart_in_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_xfer: got byte 0x%0h, expected no transfer", uart_in_data);
        end else begin
          chk("xfer_data", 32'(uart_in_data), 32'(exp_q.pop_front()));
        end
      end
      stall_q    = uart_in_valid && !uart_in_ready;
      stall_data = uart_in_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  // One clock of stimulus: drive inputs, advance the reference model, check status.
  task automatic cyc(input bit we, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop;
    bit acc;
    int sz;
    logic [7:0] b;
    cpu_we = we;
    cpu_wdata = d;
    uart_in_ready = rdy;
    cpu_ovf_clr = clr;
    sz = mfifo.size();
    pop = 1'b0;
    if (!mvalid) begin
      pop = (sz > 0);
    end else if (rdy) begin
      if (mcr) mcr = 1'b0;
      else if (sz > 0) pop = 1'b1;
      else mvalid = 1'b0;
    end
    if (pop) begin
      b = mfifo.pop_front();
      mvalid = 1'b1;
      mcr = CRLF && (b == 8'h0A);
    end
    acc = we && ((sz < DEPTH) || pop);
    if (acc) begin
      mfifo.push_back(d);
      if (CRLF && (d == 8'h0A)) exp_q.push_back(8'h0D);
      exp_q.push_back(d);
    end
    if (we && !acc) movf = 1'b1;
    else if (clr) movf = 1'b0;
    @(posedge clk);
    #1;
    chk("status", 32'(cpu_status), 32'(exp_status()));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    cpu_we = 1'b0;
    cpu_ovf_clr = 1'b0;
    #1;
    chk("rst_valid", 32'(uart_in_valid), 32'd0);
    chk("rst_data", 32'(uart_in_data), 32'd0);
    chk("rst_status", 32'(cpu_status), 32'h0003);
    mfifo.delete();
    exp_q.delete();
    mvalid = 1'b0;
    mcr = 1'b0;
    movf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single byte into an idle block.
    cyc(1'b1, 8'h41, 1'b1, 1'b0);
    chk("t1_level1", 32'(cpu_status[15:8]), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_valid", 32'(uart_in_valid), 32'd1);
    chk("t1_data", 32'(uart_in_data), 32'h41);
    chk("t1_level0", 32'(cpu_status[15:8]), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_idle", 32'(cpu_status), 32'h0003);

    // Stalled sink: 17 bytes fill output register plus FIFO, 18th overflows.
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_full", 32'(cpu_status), 32'h1008);
    chk("t2_head", 32'(uart_in_data), 32'h00);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t2_ovf", 32'(cpu_status), 32'h100C);

    // Release the sink: drain in order at one per clock, then clear overflow.
    repeat (18) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_drained", 32'(cpu_status), 32'h0007);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(cpu_status), 32'h0003);

    // Full FIFO with a write in the same cycle as a pop.
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t4_push_on_pop", 32'(cpu_status), 32'h1008);
    repeat (20) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Text with a newline.
    cyc(1'b1, 8'h61, 1'b1, 1'b0);
    cyc(1'b1, 8'h0A, 1'b1, 1'b0);
    cyc(1'b1, 8'h62, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_delivered", 32'(exp_q.size()), 32'd0);

    // Reset while the newline is being presented; nothing may follow release.
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    cyc(1'b1, 8'h0A, 1'b0, 1'b0);
    cyc(1'b1, 8'h62, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_nl_head", 32'(uart_in_data), CRLF ? 32'h0D : 32'h0A);
    do_reset();
    repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random write/ready traffic.
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 9) < 6, 8'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 49) == 0);
    end
    repeat (2 * DEPTH + 8) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
